// File: rtl/vga_bus_pkg.sv
// Shared constants and state encoding for the VGA/ROM bus arbiter.
// Index constants name the drawing engines in priority order.
package vga_bus_pkg;
  localparam int ADDR_W  = 16;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int RGB_W   = 24;
  localparam int NUM_REQ = 3;

  localparam int REQ_MAP   = 0;
  localparam int REQ_TILE  = 1;
  localparam int REQ_SCORE = 2;

  localparam int unsigned TIMEOUT_CYCLES = 800000;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } arb_state_t;
endpackage

// File: rtl/prio_onehot_picker.sv
// Lowest-index-wins picker: one-hot plus binary index of the winner.
// Index 0 has highest priority.
module prio_onehot_picker
  import vga_bus_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_bus_arbiter.sv
// Job-granular arbiter sharing the ROM address and VGA plot ports
// between the drawing engines; a watchdog reclaims stuck grants.
module vga_bus_arbiter #(
  parameter int          NUM_REQ        = vga_bus_pkg::NUM_REQ,
  parameter int          ADDR_W         = vga_bus_pkg::ADDR_W,
  parameter int          X_W            = vga_bus_pkg::X_W,
  parameter int          Y_W            = vga_bus_pkg::Y_W,
  parameter int          RGB_W          = vga_bus_pkg::RGB_W,
  parameter int unsigned TIMEOUT_CYCLES = vga_bus_pkg::TIMEOUT_CYCLES
) (
  input  logic                       CLOCK_50,
  input  logic                       frame_reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_rom_addr,
  input  logic [NUM_REQ-1:0]         req_plot,
  input  logic [NUM_REQ*X_W-1:0]     req_x,
  input  logic [NUM_REQ*Y_W-1:0]     req_y,
  input  logic [NUM_REQ*RGB_W-1:0]   req_rgb,
  output logic [NUM_REQ-1:0]         grant,
  output logic [ADDR_W-1:0]          rom_address,
  output logic                       vga_plot,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [RGB_W-1:0]           vga_colour,
  output logic                       busy,
  output logic                       timeout_err
);
  import vga_bus_pkg::*;

  localparam int IDX_W =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t         state;
  arb_state_t         state_nx;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] grant_q;
  logic [WD_W-1:0]    wd;
  logic [ADDR_W-1:0]  rom_hold;
  logic               plot_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [RGB_W-1:0]   rgb_q;
  logic               terr_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               own_req;
  logic               own_done;
  logic               own_plot;
  logic [ADDR_W-1:0]  own_addr;
  logic [X_W-1:0]     own_x;
  logic [Y_W-1:0]     own_y;
  logic [RGB_W-1:0]   own_rgb;
  logic               wd_hit;
  logic               leave;

  prio_onehot_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Only the owner's slot is ever looked at.
  always_comb begin
    own_req  = 1'b0;
    own_done = 1'b0;
    own_plot = 1'b0;
    own_addr = '0;
    own_x    = '0;
    own_y    = '0;
    own_rgb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        own_req  = req[i];
        own_done = done[i];
        own_plot = req_plot[i];
        own_addr = req_rom_addr[i*ADDR_W +: ADDR_W];
        own_x    = req_x[i*X_W +: X_W];
        own_y    = req_y[i*Y_W +: Y_W];
        own_rgb  = req_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  always_comb begin
    state_nx = state;
    wd_hit   = (wd == WD_LAST);
    leave    = own_done | ~own_req | wd_hit;
    unique case (state)
      IDLE: if (pick_any) state_nx = OWN;
      OWN:  if (leave) state_nx = GAP;
      GAP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
    if (frame_reset) begin
      state    <= IDLE;
      owner    <= '0;
      grant_q  <= '0;
      wd       <= '0;
      rom_hold <= '0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      rgb_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_any) begin
        owner   <= pick_idx;
        grant_q <= pick_onehot;
        wd      <= '0;
      end
      if (state == OWN) begin
        rom_hold <= own_addr;
        x_q      <= own_x;
        y_q      <= own_y;
        rgb_q    <= own_rgb;
        if (wd != '1) wd <= wd + WD_W'(1);
        if (leave) grant_q <= '0;
        if (wd_hit) terr_q <= 1'b1;
      end
      // A pixel on the releasing cycle is dropped so GAP stays dark.
      plot_q <= (state == OWN) && !leave && own_plot;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state == OWN);
  assign rom_address = (state == OWN) ? own_addr : rom_hold;
  assign vga_plot    = plot_q;
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign vga_colour  = rgb_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_vga_bus_arbiter.sv
// Self-checking bench for vga_bus_arbiter: arbitration table,
// pixel scoreboard, isolation, watchdog and reset-mid-job sequences.
module tb_vga_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req, done, plot;
  logic [47:0] rom;
  logic [23:0] xs;
  logic [20:0] ys;
  logic [71:0] rgbs;

  logic [2:0]  grant, grant_w;
  logic [15:0] rom_address, rom_address_w;
  logic        vga_plot, vga_plot_w;
  logic [7:0]  vga_x, vga_x_w;
  logic [6:0]  vga_y, vga_y_w;
  logic [23:0] vga_colour, vga_colour_w;
  logic        busy, busy_w, terr, terr_w;

  vga_bus_arbiter #(
    .NUM_REQ(3), .ADDR_W(16), .X_W(8), .Y_W(7), .RGB_W(24),
    .TIMEOUT_CYCLES(800000)
  ) dut (
    .CLOCK_50(clk), .frame_reset(rst),
    .req(req), .done(done), .req_rom_addr(rom),
    .req_plot(plot), .req_x(xs), .req_y(ys), .req_rgb(rgbs),
    .grant(grant), .rom_address(rom_address),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .busy(busy), .timeout_err(terr)
  );

  // Short watchdog copy; shares all stimulus with dut.
  vga_bus_arbiter #(
    .NUM_REQ(3), .ADDR_W(16), .X_W(8), .Y_W(7), .RGB_W(24),
    .TIMEOUT_CYCLES(16)
  ) dut_wd (
    .CLOCK_50(clk), .frame_reset(rst),
    .req(req), .done(done), .req_rom_addr(rom),
    .req_plot(plot), .req_x(xs), .req_y(ys), .req_rgb(rgbs),
    .grant(grant_w), .rom_address(rom_address_w),
    .vga_plot(vga_plot_w), .vga_x(vga_x_w), .vga_y(vga_y_w),
    .vga_colour(vga_colour_w), .busy(busy_w),
    .timeout_err(terr_w)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit sb_on  = 1'b1;
  bit iso_on = 1'b0;

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] rgb;
    int          at;
  } px_t;
  px_t sb[$];

  typedef struct {
    logic [2:0]  rq;
    logic [2:0]  g;
    logic [15:0] ra;
  } vec_t;
  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int i, input logic p,
                        input logic [7:0] x, input logic [6:0] y,
                        input logic [23:0] c, input bit expect_out);
    plot[i]            = p;
    xs[i*8 +: 8]       = x;
    ys[i*7 +: 7]       = y;
    rgbs[i*24 +: 24]   = c;
    if (p && expect_out && sb_on) begin
      px_t e;
      e.x = x; e.y = y; e.rgb = c; e.at = cyc + 1;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    px_t e;
    if (sb_on && vga_plot) begin
      if (sb.size() == 0) begin
        chk("spurious_plot", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("px_x", vga_x, e.x);
        chk("px_y", vga_y, e.y);
        chk("px_rgb", vga_colour, e.rgb);
        chk("px_cycle", cyc, e.at);
      end
    end
    if (iso_on) chk("iso_x", vga_x == 8'hAA, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired want finished");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{3'b000, 3'b000, 16'h0000};
    vecs[1] = '{3'b001, 3'b001, 16'h1234};
    vecs[2] = '{3'b010, 3'b010, 16'h4B00};
    vecs[3] = '{3'b100, 3'b100, 16'hC0DE};
    vecs[4] = '{3'b011, 3'b001, 16'h1234};
    vecs[5] = '{3'b110, 3'b010, 16'h4B00};
    vecs[6] = '{3'b101, 3'b001, 16'h1234};
    vecs[7] = '{3'b111, 3'b001, 16'h1234};

    rst = 1'b1;
    req = '0; done = '0; plot = '0;
    rom = '0; xs = '0; ys = '0; rgbs = '0;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_rom", rom_address, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour} != 0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", terr, 0);
    rst = 1'b0;
    tick();

    // Arbitration table; release each grant by dropping req.
    rom = {16'hC0DE, 16'h4B00, 16'h1234};
    foreach (vecs[k]) begin
      req = vecs[k].rq;
      tick();
      chk("vec_grant", grant, vecs[k].g);
      chk("vec_busy", busy, vecs[k].g != 0);
      chk("vec_rom", rom_address, vecs[k].ra);
      req = '0;
      tick();
      chk("vec_release", {busy, grant}, 0);
      tick();
    end

    // Single requester: 64 pixels, done later.
    req = 3'b010;
    tick();
    chk("single_grant", grant, 3'b010);
    for (int i = 0; i < 64; i++) begin
      set_px(1, 1'b1, 8'(8 + i % 8), 7'(16 + i / 8),
             24'hFF0000, 1'b1);
      tick();
    end
    plot = '0;
    repeat (5) tick();
    done = 3'b010;
    tick();
    chk("single_gap_grant", grant, 0);
    chk("single_gap_busy", busy, 0);
    chk("single_gap_plot", vga_plot, 0);
    chk("single_sb_drain", sb.size(), 0);
    done = '0;
    req = '0;
    tick();

    // Contention with isolation of requester 1.
    set_px(1, 1'b0, 8'hAA, 7'h11, 24'h00AA00, 1'b0);
    req = 3'b111;
    tick();
    chk("cont_grant0", grant, 3'b001);
    iso_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rom[0 +: 16]  = 16'h0100 + 16'(i);
      rom[16 +: 16] = 16'h4B00 + 16'(i);
      set_px(0, 1'b1, 8'(i), 7'(i), 24'h000010 + 24'(i), 1'b1);
      set_px(1, 1'(i & 1), 8'hAA, 7'h11, 24'h00AA00, 1'b0);
      #1;
      chk("iso_rom", rom_address, 16'h0100 + 16'(i));
      tick();
    end
    plot = '0;
    tick();
    tick();
    iso_on = 1'b0;
    done = 3'b010;
    tick();
    chk("nonowner_done0", grant, 3'b001);
    done = 3'b001;
    tick();
    chk("cont_gap0", {busy, grant, vga_plot}, 0);
    rom[0 +: 16] = 16'hFFFF;
    #1;
    chk("gap_rom_hold", rom_address, 16'h0107);
    done = '0;
    req = 3'b110;
    tick();
    chk("cont_idle", grant, 0);
    tick();
    chk("cont_grant1", grant, 3'b010);
    rom[16 +: 16] = 16'h4B00;
    #1;
    chk("rom_path", rom_address, 16'h4B00);
    done = 3'b100;
    tick();
    chk("nonowner_done1", grant, 3'b010);
    done = 3'b010;
    tick();
    chk("cont_gap1", grant, 0);
    done = '0;
    req = 3'b100;
    tick();
    tick();
    chk("cont_grant2", grant, 3'b100);
    done = 3'b100;
    tick();
    chk("regrant_gap", grant, 0);
    done = '0;
    tick();
    tick();
    chk("regrant_same", grant, 3'b100);
    req = '0;
    tick();
    chk("cont_final_rel", grant, 0);
    tick();

    // Watchdog on the short-timeout copy.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req = 3'b100;
    tick();
    chk("wd_grant", grant_w, 3'b100);
    n = 0;
    while (grant_w != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("wd_release_cycles", n, 16);
    chk("wd_terr_set", terr_w, 1);
    chk("wd_main_terr", terr, 0);
    chk("wd_main_grant", grant, 3'b100);
    req = '0;
    repeat (4) tick();
    chk("wd_terr_sticky", terr_w, 1);
    rst = 1'b1;
    #1;
    chk("wd_terr_cleared", terr_w, 0);
    rst = 1'b0;
    tick();

    // Reset while the owner is plotting.
    sb_on = 1'b0;
    req = 3'b001;
    tick();
    set_px(0, 1'b1, 8'h33, 7'h22, 24'h123456, 1'b0);
    tick();
    chk("mid_pre_plot", vga_plot, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_grant", grant, 0);
    chk("mid_plot", vga_plot, 0);
    chk("mid_zero", {busy, rom_address, vga_x, vga_y, vga_colour}, 0);
    tick();
    chk("mid_hold", {grant, vga_plot}, 0);
    plot = '0;
    #3;
    rst = 1'b0;
    tick();
    chk("mid_rearb", grant, 3'b001);
    req = '0;
    tick();
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
